// File: rtl/sphere_ray_scan_pkg.sv
// Shared types, constants and the Q32.32 -> Q16.16 saturating reduction used by
// the ray/sphere visibility scanner.
package sphere_pkg;

   localparam int NUM_SPHERES = 4;

   typedef logic signed [63:0] fixed_real;
   typedef struct packed {
      fixed_real x;
      fixed_real y;
      fixed_real z;
   } vector;
   typedef logic [23:0] color;

   typedef logic signed [31:0] q16_t;
   typedef struct packed {
      q16_t x;
      q16_t y;
      q16_t z;
   } vec_q16;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_AIM,
      ST_ISSUE,
      ST_WAIT,
      ST_LOAD,
      ST_MUL,
      ST_DISC,
      ST_UPDATE,
      ST_DONE
   } state_t;

   // Largest and smallest Q32.32 values whose bits [47:16] still represent them.
   localparam fixed_real Q16_LIM_HI = 64'sh0000_7FFF_FFFF_FFFF;
   localparam fixed_real Q16_LIM_LO = 64'shFFFF_8000_0000_0000;

   function automatic q16_t q16_sat(input fixed_real v);
      q16_t r;
      if (v > Q16_LIM_HI)
         r = 32'sh7FFF_FFFF;
      else if (v < Q16_LIM_LO)
         r = 32'sh8000_0000;
      else
         r = $signed(v[47:16]);
      return r;
   endfunction

   function automatic vec_q16 vec_sat(input vector v);
      vec_q16 r;
      r.x = q16_sat(v.x);
      r.y = q16_sat(v.y);
      r.z = q16_sat(v.z);
      return r;
   endfunction

endpackage

// File: rtl/sphere_ray_scan_dot3_q16.sv
// Combinational three-term signed dot product of Q16.16 vectors; each product is
// Q32.32 and the sum is carried at 66 bits so it can never overflow.
module dot3_q16
   import sphere_pkg::*;
(
   input  logic [95:0] u,
   input  logic [95:0] v,
   output logic [65:0] dot
);

   vec_q16 uq;
   vec_q16 vq;
   logic signed [63:0] px;
   logic signed [63:0] py;
   logic signed [63:0] pz;
   logic signed [65:0] sum;

   assign uq = u;
   assign vq = v;

   assign px = 64'(uq.x) * 64'(vq.x);
   assign py = 64'(uq.y) * 64'(vq.y);
   assign pz = 64'(uq.z) * 64'(vq.z);

   assign sum = 66'(px) + 66'(py) + 66'(pz);
   assign dot = sum;

endmodule

// File: rtl/sphere_ray_scan.sv
// Per-pixel ray/sphere visibility scanner over the four-sphere register bank.
// Optional macro SPHERE_SCAN_HIT_FEEDBACK_EN drives Hit/Hit_index back to the bank.
module sphere_ray_scan
   import sphere_pkg::*;
#(
   parameter int          RADIUS_INT = 480,
   parameter logic [23:0] BG_COL     = 24'h000000
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [191:0] Ray_dir,
   output logic [1:0]   Read_index,
   input  logic [191:0] Sphere_pos,
   input  logic [1:0]   curr_index,
   input  logic [95:0]  Sphere_col,
   output logic         Busy,
   output logic         Done,
   output logic         Pixel_hit,
   output logic [1:0]   Pixel_index,
   output logic [23:0]  Pixel_col,
   output logic         Hit,
   output logic [1:0]   Hit_index
);

   localparam longint            RAD2   = longint'(RADIUS_INT) * longint'(RADIUS_INT);
   localparam logic signed [65:0] RAD2_Q = 66'(RAD2) <<< 32;

   state_t state;
   state_t state_nxt;

   logic [1:0] k_q;
   logic [1:0] ri_hold;

   vec_q16 dir_p0;
   vec_q16 cen_p1;
   logic   tag_ok_p1;
   logic signed [65:0] aa_p1;
   logic signed [65:0] bb_p2;
   logic signed [65:0] cc_p2;
   logic   hit_p3;

   logic              best_valid;
   logic [1:0]        best_idx;
   color              best_col;
   logic signed [65:0] best_c;

   logic [3:0][23:0] col_arr;
   logic [95:0]      ab_v;
   logic [65:0]      dot_ab;
   logic [65:0]      dot_cc;
   logic [131:0]     bsq;
   logic [131:0]     acq;
   logic             hit_d;
   logic             take;

   assign col_arr = Sphere_col;

   // The b instance also forms a = D.D while aiming.
   assign ab_v = (state == ST_AIM) ? dir_p0 : cen_p1;

   dot3_q16 u_dot_b (
      .u   (dir_p0),
      .v   (ab_v),
      .dot (dot_ab)
   );

   dot3_q16 u_dot_c (
      .u   (cen_p1),
      .v   (cen_p1),
      .dot (dot_cc)
   );

   // Discriminant test; a.c is only consulted when c is non-negative.
   assign bsq   = 132'($unsigned(bb_p2)) * 132'($unsigned(bb_p2));
   assign acq   = 132'($unsigned(aa_p1)) * 132'($unsigned(cc_p2));
   assign hit_d = tag_ok_p1 & ~bb_p2[65] & (bb_p2 != '0) & (cc_p2[65] | (bsq >= acq));

   // Strict less-than keeps the lower index on equal c.
   assign take = (state == ST_UPDATE) && hit_p3 && (!best_valid || (cc_p2 < best_c));

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (Start) state_nxt = ST_AIM;
         ST_AIM:    state_nxt = ST_ISSUE;
         ST_ISSUE:  state_nxt = ST_WAIT;
         ST_WAIT:   state_nxt = ST_LOAD;
         ST_LOAD:   state_nxt = ST_MUL;
         ST_MUL:    state_nxt = ST_DISC;
         ST_DISC:   state_nxt = ST_UPDATE;
         ST_UPDATE: state_nxt = (k_q == 2'd3) ? ST_DONE : ST_ISSUE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   assign Busy       = (state != ST_IDLE);
   assign Done       = (state == ST_DONE);
   assign Read_index = (state == ST_ISSUE) ? k_q : ri_hold;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= ST_IDLE;
         k_q         <= 2'd0;
         ri_hold     <= 2'd0;
         best_valid  <= 1'b0;
         Pixel_hit   <= 1'b0;
         Pixel_index <= 2'd0;
         Pixel_col   <= BG_COL;
      end else begin
         state <= state_nxt;
         if (state == ST_ISSUE)
            ri_hold <= k_q;
         if (state == ST_AIM) begin
            k_q        <= 2'd0;
            best_valid <= 1'b0;
         end
         if (state == ST_UPDATE) begin
            k_q <= k_q + 2'd1;
            if (take)
               best_valid <= 1'b1;
         end
         // Results land together with the final ranking step so they are valid in DONE.
         if ((state == ST_UPDATE) && (k_q == 2'd3)) begin
            Pixel_hit <= best_valid | take;
            if (take) begin
               Pixel_index <= k_q;
               Pixel_col   <= col_arr[k_q];
            end else if (best_valid) begin
               Pixel_index <= best_idx;
               Pixel_col   <= best_col;
            end else begin
               Pixel_index <= 2'd0;
               Pixel_col   <= BG_COL;
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      // p0: ray direction captured at start
      if ((state == ST_IDLE) && Start)
         dir_p0 <= vec_sat(Ray_dir);
      // p1: a, centre and tag check
      if (state == ST_AIM)
         aa_p1 <= $signed(dot_ab);
      if (state == ST_LOAD) begin
         cen_p1    <= vec_sat(Sphere_pos);
         tag_ok_p1 <= (curr_index == k_q);
      end
      // p2: b and c
      if (state == ST_MUL) begin
         bb_p2 <= $signed(dot_ab);
         cc_p2 <= $signed(dot_cc) - RAD2_Q;
      end
      // p3: hit decision
      if (state == ST_DISC)
         hit_p3 <= hit_d;
      if (take) begin
         best_c   <= cc_p2;
         best_idx <= k_q;
         best_col <= col_arr[k_q];
      end
   end

`ifdef SPHERE_SCAN_HIT_FEEDBACK_EN
   assign Hit       = Done & Pixel_hit;
   assign Hit_index = Done ? Pixel_index : 2'd0;
`else
   assign Hit       = 1'b0;
   assign Hit_index = 2'd0;
`endif

endmodule

// File: tb/tb_sphere_ray_scan.sv
// Directed bench for sphere_ray_scan with a registered-read model of the sphere bank.
module tb_sphere_ray_scan;

   localparam logic [23:0] BG = 24'h102030;
`ifdef SPHERE_SCAN_HIT_FEEDBACK_EN
   localparam bit FB = 1'b1;
`else
   localparam bit FB = 1'b0;
`endif

   logic         Clk;
   logic         Reset;
   logic         Start;
   logic [191:0] Ray_dir;
   logic [1:0]   Read_index;
   logic [191:0] Sphere_pos;
   logic [1:0]   curr_index;
   logic [95:0]  Sphere_col;
   logic         Busy;
   logic         Done;
   logic         Pixel_hit;
   logic [1:0]   Pixel_index;
   logic [23:0]  Pixel_col;
   logic         Hit;
   logic [1:0]   Hit_index;

   logic [191:0] pos [4];
   logic [23:0]  col [4];
   logic [3:0]   tag_bad;

   int total;
   int bad;

   sphere_ray_scan #(
      .RADIUS_INT (480),
      .BG_COL     (BG)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Start       (Start),
      .Ray_dir     (Ray_dir),
      .Read_index  (Read_index),
      .Sphere_pos  (Sphere_pos),
      .curr_index  (curr_index),
      .Sphere_col  (Sphere_col),
      .Busy        (Busy),
      .Done        (Done),
      .Pixel_hit   (Pixel_hit),
      .Pixel_index (Pixel_index),
      .Pixel_col   (Pixel_col),
      .Hit         (Hit),
      .Hit_index   (Hit_index)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Bank model: one-cycle registered read with optional tag corruption.
   assign Sphere_col = {col[3], col[2], col[1], col[0]};
   always @(posedge Clk) begin
      Sphere_pos <= pos[Read_index];
      curr_index <= tag_bad[Read_index] ? ~Read_index : Read_index;
   end

   function automatic logic [191:0] v3(input int x, input int y, input int z);
      return {x, 32'd0, y, 32'd0, z, 32'd0};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_spheres(input logic [191:0] p0, input logic [191:0] p1,
                              input logic [191:0] p2, input logic [191:0] p3);
      pos[0] = p0;
      pos[1] = p1;
      pos[2] = p2;
      pos[3] = p3;
   endtask

   task automatic scan(input string tag, input logic [191:0] dir, input bit exp_hit,
                       input logic [1:0] exp_idx, input logic [23:0] exp_col, input bit poke);
      int n;
      @(negedge Clk);
      Ray_dir = dir;
      Start   = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      n     = 1;
      check({tag, "_busy"}, 64'(Busy), 64'd1);
      while (Done !== 1'b1 && n < 60) begin
         if (n == 8)  check({tag, "_ri1"}, 64'(Read_index), 64'd1);
         if (n == 21) check({tag, "_ri3"}, 64'(Read_index), 64'd3);
         Start = poke && (n == 5);
         if (Start) Ray_dir = v3(-1, 0, 0);
         @(negedge Clk);
         n++;
      end
      Start = 1'b0;
      check({tag, "_latency"}, 64'(n), 64'd26);
      check({tag, "_pixhit"}, 64'(Pixel_hit), 64'(exp_hit));
      check({tag, "_pixcol"}, 64'(Pixel_col), 64'(exp_col));
      if (exp_hit) check({tag, "_pixidx"}, 64'(Pixel_index), 64'(exp_idx));
      check({tag, "_hit"}, 64'(Hit), 64'(FB & exp_hit));
      if (exp_hit || !FB) check({tag, "_hitidx"}, 64'(Hit_index), FB ? 64'(exp_idx) : 64'd0);
      @(negedge Clk);
      check({tag, "_done_off"}, 64'(Done), 64'd0);
      check({tag, "_busy_off"}, 64'(Busy), 64'd0);
      check({tag, "_hit_off"}, 64'(Hit), 64'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"}, 64'(Busy), 64'd0);
      check({tag, "_done"}, 64'(Done), 64'd0);
      check({tag, "_ri"}, 64'(Read_index), 64'd0);
      check({tag, "_pixhit"}, 64'(Pixel_hit), 64'd0);
      check({tag, "_pixidx"}, 64'(Pixel_index), 64'd0);
      check({tag, "_pixcol"}, 64'(Pixel_col), 64'(BG));
      check({tag, "_hit"}, 64'(Hit), 64'd0);
      check({tag, "_hitidx"}, 64'(Hit_index), 64'd0);
   endtask

   initial begin
      int n;
      int done_seen;
      total   = 0;
      bad     = 0;
      Reset   = 1'b1;
      Start   = 1'b0;
      Ray_dir = '0;
      tag_bad = 4'b0000;
      col[0]  = 24'hAA0001;
      col[1]  = 24'hBB0002;
      col[2]  = 24'hCC0003;
      col[3]  = 24'hDD0004;
      set_spheres('0, '0, '0, '0);
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      check_reset_values("rst");

      // Equal distances: all four hit, lowest index wins.
      set_spheres(v3(2400, 0, 0), v3(2400, 0, 0), v3(2400, 0, 0), v3(2400, 0, 0));
      scan("equal", v3(1, 0, 0), 1'b1, 2'd0, 24'hAA0001, 1'b0);

      // Sphere 2 is nearest.
      set_spheres(v3(4800, 0, 0), v3(4800, 0, 0), v3(1200, 0, 0), v3(4800, 0, 0));
      scan("near2", v3(1, 0, 0), 1'b1, 2'd2, 24'hCC0003, 1'b0);

      // Everything behind the ray.
      set_spheres(v3(2400, 0, 0), v3(1200, 100, 0), v3(600, 0, 50), v3(3000, 0, 0));
      scan("behind", v3(-1, 0, 0), 1'b0, 2'd0, BG, 1'b0);

      // Grazing limits: offset 481 misses, 479 hits.
      set_spheres(v3(2400, 481, 0), v3(-2400, 0, 0), v3(-2400, 0, 0), v3(-2400, 0, 0));
      scan("graze481", v3(1, 0, 0), 1'b0, 2'd0, BG, 1'b0);
      set_spheres(v3(2400, 479, 0), v3(-2400, 0, 0), v3(-2400, 0, 0), v3(-2400, 0, 0));
      scan("graze479", v3(1, 0, 0), 1'b1, 2'd0, 24'hAA0001, 1'b0);

      // Tag mismatch on the only candidate, plus a Start poked mid-scan.
      set_spheres(v3(2400, 0, 0), v3(-2400, 0, 0), v3(-2400, 0, 0), v3(-2400, 0, 0));
      tag_bad = 4'b0001;
      scan("tagbad", v3(1, 0, 0), 1'b0, 2'd0, BG, 1'b1);
      tag_bad = 4'b0000;

      // Leave a hit on the outputs, then abort a scan with Reset.
      set_spheres(v3(4800, 0, 0), v3(4800, 0, 0), v3(1200, 0, 0), v3(4800, 0, 0));
      scan("prearm", v3(1, 0, 0), 1'b1, 2'd2, 24'hCC0003, 1'b0);
      @(negedge Clk);
      Ray_dir = v3(1, 0, 0);
      Start   = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      n     = 1;
      while (n < 10) begin
         @(negedge Clk);
         n++;
      end
      Reset = 1'b1;
      #1;
      check_reset_values("abort");
      @(negedge Clk);
      Reset     = 1'b0;
      done_seen = 0;
      repeat (40) begin
         @(negedge Clk);
         if (Done === 1'b1) done_seen++;
      end
      check("abort_no_done", 64'(done_seen), 64'd0);
      check("abort_idle", 64'(Busy), 64'd0);

      scan("recover", v3(1, 0, 0), 1'b1, 2'd2, 24'hCC0003, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sphere_ray_scan.md
# sphere_ray_scan

Per-pixel ray/sphere visibility scanner that sits directly downstream of the four-sphere position/colour register bank. On each `Start` it takes a camera ray direction and walks `Read_index` over spheres 0..3. It captures each returned `Sphere_pos` one cycle later, tests ray/sphere intersection in fixed point, and reports the nearest hit sphere's index and colour, or the background colour.

## Interface
Parameters:
- `RADIUS_INT`, default 480: sphere radius, integer world units; the same radius applies to all spheres.
- `BG_COL`, default 24'h000000: colour output on a miss.

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: reset, asynchronous, active-high.
- `Start` in 1: request a scan; `Ray_dir` is valid in the same cycle.
- `Ray_dir` in 192: `vector`, 3 × Q32.32 signed; the ray origin is (0,0,0).
- `Read_index` out 2: sphere select to the register bank.
- `Sphere_pos` in 192: centre of the sphere addressed by `Read_index` one cycle earlier.
- `curr_index` in 2: index tag returned alongside `Sphere_pos`.
- `Sphere_col` in 96: `color[3:0]`, all four sphere colours, combinational.
- `Busy` out 1: high whenever the FSM is not in IDLE.
- `Done` out 1: one-cycle pulse; the `Pixel_*` outputs are valid from this cycle.
- `Pixel_hit` out 1: at least one sphere was hit.
- `Pixel_index` out 2: index of the nearest hit sphere.
- `Pixel_col` out 24: colour of the nearest hit sphere, else `BG_COL`.
- `Hit` out 1, `Hit_index` out 2: feedback to the register bank (see Configuration).

## Operation
- FSM states: IDLE, AIM, then for each k = 0..3: ISSUE, WAIT, LOAD, MUL, DISC, UPDATE; then DONE.
- IDLE: a high `Start` latches `Ray_dir` into D. Next state is AIM.
- AIM: computes and registers a = D·D. Clears best_valid and sets k = 0.
- ISSUE: drives `Read_index` = k. `Read_index` holds its value outside ISSUE.
- WAIT: absorbs the bank's registered-read latency.
- LOAD: captures `Sphere_pos` into C and records tag_ok = (`curr_index` == k).
- MUL: registers b = D·C and c = C·C − (RADIUS_INT² << 32).
- DISC: computes hit_k = tag_ok & (b > 0) & ((c < 0) | (b·b ≥ a·c)).
- UPDATE: if hit_k and (!best_valid or c < best_c), sets best_c = c, best_idx = k, best_col = `Sphere_col`[k], best_valid = 1. Then k++, returning to ISSUE, or going to DONE after k = 3.
- DONE: `Done` = 1 and the `Pixel_*` outputs are updated from the best_* registers. Next state is IDLE.
- Arithmetic and widths:
  - Each Q32.32 component is reduced to signed Q16.16 by taking bits [47:16]. Values outside ±2^15 integer range saturate to 32'h7FFFFFFF / 32'h80000000.
  - Each product is 64-bit Q32.32. Each dot product is the 66-bit signed sum of three products.
  - b·b and a·c are formed as 132-bit unsigned products; both are non-negative when evaluated.
- Nearest-sphere ranking uses c (centre distance²), not ray parameter t. On equal c the lower index wins.
- A `curr_index` mismatch forces a miss for that sphere only; scanning continues.
- `Start` outside IDLE is ignored, with no queuing.

## Timing
- Scan latency: `Start` sampled at edge 0 → `Done` high in the cycle after edge 25. Total is 26 cycles, and the next `Start` is accepted at the earliest in the cycle after `Done`.
- `Busy` rises the cycle after `Start` and falls with the return to IDLE.
- Reset values:
  - State IDLE.
  - `Read_index` = 0, `Busy` = 0, `Done` = 0.
  - `Pixel_hit` = 0, `Pixel_index` = 0, `Pixel_col` = `BG_COL`.
  - `Hit` = 0, `Hit_index` = 0.
- `Reset` mid-scan aborts immediately, with no `Done` and no `Hit`.
- Colour is sampled at UPDATE. A frame tick in the bank during a scan may therefore mix pre- and post-update data; this is acceptable.

## Configuration
- `SPHERE_SCAN_HIT_FEEDBACK_EN` defined: in the DONE cycle, `Hit` = `Pixel_hit` and `Hit_index` = `Pixel_index`. This is a one-cycle pulse that drives the bank's `Hit`/`Hit_index`.
- Undefined: `Hit` and `Hit_index` are tied to 0. All other behaviour is identical.

## Structure
- Shared package `sphere_pkg`:
  - typedefs `vector`, `fixed_real`, `color`.
  - `NUM_SPHERES` = 4.
  - Q16.16 saturating-truncate function.
- One sub-module, `dot3_q16`: combinational three-term signed dot product of Q16.16 inputs producing a 66-bit result. It is instantiated twice, for b and c (and reused for a).

## Test plan
- D = (1,0,0), all spheres at (2400,0,0), RADIUS_INT = 480 → hit on all four with equal c; `Pixel_index` = 0, `Pixel_col` = `Sphere_col`[0], `Done` exactly 26 cycles after `Start`.
- D = (1,0,0); sphere 2 at (1200,0,0), others at (4800,0,0) → `Pixel_index` = 2.
- D = (−1,0,0), all centres with positive component 2 → b < 0 on every sphere; `Pixel_hit` = 0, `Pixel_col` = `BG_COL`.
- Sphere centre at (2400,481,0), D = (1,0,0), R = 480 → miss; centre at (2400,479,0) → hit.
- Force `curr_index` ≠ `Read_index` for sphere 0, which is the only hit candidate → `Pixel_hit` = 0. Also assert `Start` while `Busy` and confirm it is ignored.
- Assert `Reset` at cycle 10 of a scan → all outputs return to reset values and no `Done` is produced. With `SPHERE_SCAN_HIT_FEEDBACK_EN` defined, a hitting scan gives `Hit` = 1 for exactly one cycle, coincident with `Done`.
